// File: rtl/laser_window_sched.sv
// laser_window_sched - MEMS-angle driven laser gate with double-buffered window table.
// Angle/zero flags are synchronized; the active table only changes between sweeps while running.
module laser_window_sched #(
  parameter int N_WIN       = 8,
  parameter int CNT_W       = 12,
  parameter int WDOG_CYCLES = 5000000
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             en,
  input  logic             signal_angle,
  input  logic             signal_mid,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_start,
  input  logic [CNT_W-1:0] cfg_stop,
  input  logic             cfg_en,
  input  logic             cfg_commit,
  output logic             commit_pending,
  output logic             laser,
  output logic [1:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] angle_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam int               WD_W    = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             ang_sync1_q, ang_sync2_q;
  logic             mid_sync1_q, mid_sync2_q;
  logic             angle_edge, zero_edge;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] angle_cnt_q, angle_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             pending_q, pending_d;
  logic             laser_q, laser_d;
  logic             commit_apply;
  logic             wr_ok;
  logic             hit;

  logic [CNT_W-1:0] sh_start_q  [N_WIN];
  logic [CNT_W-1:0] sh_stop_q   [N_WIN];
  logic             sh_en_q     [N_WIN];
  logic [CNT_W-1:0] act_start_q [N_WIN];
  logic [CNT_W-1:0] act_stop_q  [N_WIN];
  logic             act_en_q    [N_WIN];

  assign angle_edge = ang_sync1_q & ~ang_sync2_q;
  assign zero_edge  = mid_sync1_q & ~mid_sync2_q;

  // In RUN the swap waits for the zero flag so a sweep never mixes two tables.
  assign commit_apply = pending_q && ((state_q != RUN) || zero_edge);
  assign wr_ok        = cfg_we && (32'(cfg_addr) < N_WIN);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_WIN; i++) begin
      if (act_en_q[i] && (angle_cnt_q >= act_start_q[i]) && (angle_cnt_q < act_stop_q[i])) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    angle_cnt_d = angle_cnt_q;
    if (zero_edge) begin
      angle_cnt_d = CNT_W'(1);
    end else if (angle_edge && (angle_cnt_q != CNT_MAX)) begin
      angle_cnt_d = angle_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (commit_apply) begin
      pending_d = 1'b0;
    end else if (cfg_commit) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    wdog_d = '0;
    if ((state_q == RUN) && !zero_edge) begin
      wdog_d = (wdog_q == WD_LAST) ? wdog_q : wdog_q + WD_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (zero_edge) state_d = RUN;
        RUN:     if (!zero_edge && (wdog_q == WD_LAST)) state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  // Gating on the next state drops the laser on the very edge that leaves RUN.
  assign laser_d = (state_d == RUN) && hit;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      ang_sync1_q <= 1'b0;
      ang_sync2_q <= 1'b0;
      mid_sync1_q <= 1'b0;
      mid_sync2_q <= 1'b0;
      state_q     <= IDLE;
      angle_cnt_q <= CNT_W'(1);
      wdog_q      <= '0;
      pending_q   <= 1'b0;
      laser_q     <= 1'b0;
    end else begin
      ang_sync1_q <= signal_angle;
      ang_sync2_q <= ang_sync1_q;
      mid_sync1_q <= signal_mid;
      mid_sync2_q <= mid_sync1_q;
      state_q     <= state_d;
      angle_cnt_q <= angle_cnt_d;
      wdog_q      <= wdog_d;
      pending_q   <= pending_d;
      laser_q     <= laser_d;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WIN; i++) begin
        sh_start_q[i]  <= '0;
        sh_stop_q[i]   <= '0;
        sh_en_q[i]     <= 1'b0;
        act_start_q[i] <= '0;
        act_stop_q[i]  <= '0;
        act_en_q[i]    <= 1'b0;
      end
    end else begin
      if (commit_apply) begin
        for (int i = 0; i < N_WIN; i++) begin
          act_start_q[i] <= sh_start_q[i];
          act_stop_q[i]  <= sh_stop_q[i];
          act_en_q[i]    <= sh_en_q[i];
        end
      end
      if (wr_ok) begin
        sh_start_q[cfg_addr] <= cfg_start;
        sh_stop_q[cfg_addr]  <= cfg_stop;
        sh_en_q[cfg_addr]    <= cfg_en;
      end
    end
  end

  assign commit_pending = pending_q;
  assign laser          = laser_q;
  assign state          = state_q;
  assign fault          = (state_q == FAULT);
  assign angle_cnt      = angle_cnt_q;

endmodule

// File: tb/tb_laser_window_sched.sv
// tb/tb_laser_window_sched.sv - directed checks for laser_window_sched.
module tb_laser_window_sched;
  localparam int CNT_W = 12;

  logic             clk_50 = 1'b0;
  logic             rst, en, signal_angle, signal_mid;
  logic             cfg_we, cfg_en, cfg_commit;
  logic [2:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_start, cfg_stop;

  logic             commit_pending, laser, fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] angle_cnt;
  logic             commit_pending_wd, laser_wd, fault_wd;
  logic [1:0]       state_wd;
  logic [CNT_W-1:0] angle_cnt_wd;

  int checks = 0;
  int errors = 0;
  int cur;

  typedef struct {
    int target;
    bit exp_prev;
    bit exp_laser;
  } vec_t;
  vec_t vecs[10];

  laser_window_sched #(.N_WIN(8), .CNT_W(CNT_W)) dut (
    .clk_50(clk_50), .rst(rst), .en(en), .signal_angle(signal_angle), .signal_mid(signal_mid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_en(cfg_en), .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .laser(laser), .state(state), .fault(fault), .angle_cnt(angle_cnt)
  );

  laser_window_sched #(.N_WIN(8), .CNT_W(CNT_W), .WDOG_CYCLES(1000)) dut_wd (
    .clk_50(clk_50), .rst(rst), .en(en), .signal_angle(signal_angle), .signal_mid(signal_mid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_en(cfg_en), .cfg_commit(cfg_commit), .commit_pending(commit_pending_wd),
    .laser(laser_wd), .state(state_wd), .fault(fault_wd), .angle_cnt(angle_cnt_wd)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_angle();
    signal_angle = 1'b1;
    @(negedge clk_50);
    signal_angle = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic pulse_mid();
    signal_mid = 1'b1;
    @(negedge clk_50);
    signal_mid = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic write_entry(input int addr, input int start, input int stop, input bit ven);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_start = CNT_W'(start);
    cfg_stop  = CNT_W'(stop);
    cfg_en    = ven;
    @(negedge clk_50);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk_50);
    cfg_commit = 1'b0;
  endtask

  task automatic advance_to(input int t);
    while (cur < t) begin
      pulse_angle();
      cur++;
    end
  endtask

  initial begin
    vecs[0] = '{2,    1'b0, 1'b0};
    vecs[1] = '{323,  1'b0, 1'b1};
    vecs[2] = '{500,  1'b1, 1'b1};
    vecs[3] = '{879,  1'b1, 1'b0};
    vecs[4] = '{1000, 1'b0, 1'b0};
    vecs[5] = '{1450, 1'b0, 1'b0};
    vecs[6] = '{2005, 1'b0, 1'b0};
    vecs[7] = '{3000, 1'b0, 1'b1};
    vecs[8] = '{3001, 1'b1, 1'b0};
    vecs[9] = '{4095, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; signal_angle = 1'b0; signal_mid = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_start = '0; cfg_stop = '0; cfg_en = 1'b0; cfg_commit = 1'b0;
    repeat (2) @(negedge clk_50);
    chk("reset_state", 32'(state), 0);
    chk("reset_laser", 32'(laser), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_pending", 32'(commit_pending), 0);
    chk("reset_angle", 32'(angle_cnt), 1);
    rst = 1'b0;
    @(negedge clk_50);

    write_entry(0, 323, 879, 1'b1);
    write_entry(1, 1000, 1000, 1'b1);
    write_entry(2, 1500, 1400, 1'b1);
    write_entry(3, 2000, 2010, 1'b0);
    write_entry(4, 3000, 3001, 1'b1);
    chk("pending_before_commit", 32'(commit_pending), 0);
    cfg_commit = 1'b1;
    @(negedge clk_50);
    chk("pending_set_idle", 32'(commit_pending), 1);
    cfg_commit = 1'b0;
    // A write on the copy cycle must stay in the shadow table only.
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_start = 12'd1; cfg_stop = 12'd4000; cfg_en = 1'b1;
    @(negedge clk_50);
    cfg_we = 1'b0;
    chk("pending_clear_idle", 32'(commit_pending), 0);

    en = 1'b1;
    @(negedge clk_50);
    chk("idle_to_arm", 32'(state), 1);
    chk("arm_laser_off", 32'(laser), 0);
    pulse_mid();
    chk("arm_to_run", 32'(state), 2);
    chk("mid_loads_one", 32'(angle_cnt), 1);
    cur = 1;

    for (int v = 0; v < 10; v++) begin
      advance_to(vecs[v].target - 1);
      pulse_angle();
      cur++;
      chk($sformatf("vec%0d_angle", v), 32'(angle_cnt), 32'(vecs[v].target));
      chk($sformatf("vec%0d_laser_prev", v), 32'(laser), 32'(vecs[v].exp_prev));
      @(negedge clk_50);
      chk($sformatf("vec%0d_laser", v), 32'(laser), 32'(vecs[v].exp_laser));
    end

    repeat (5) pulse_angle();
    chk("angle_saturate_short", 32'(angle_cnt), 4095);

    signal_angle = 1'b1; signal_mid = 1'b1;
    @(negedge clk_50);
    signal_angle = 1'b0; signal_mid = 1'b0;
    @(negedge clk_50);
    chk("simultaneous_edges", 32'(angle_cnt), 1);
    cur = 1;

    write_entry(0, 100, 200, 1'b1);
    write_entry(5, 0, 0, 1'b0);
    commit();
    chk("run_pending_set", 32'(commit_pending), 1);
    commit();
    chk("run_pending_repeat", 32'(commit_pending), 1);
    advance_to(150);
    @(negedge clk_50);
    chk("old_window_150", 32'(laser), 0);
    chk("run_pending_hold", 32'(commit_pending), 1);
    advance_to(323);
    @(negedge clk_50);
    chk("old_window_323", 32'(laser), 1);
    pulse_mid();
    chk("run_pending_clear", 32'(commit_pending), 0);
    chk("run_mid_angle", 32'(angle_cnt), 1);
    cur = 1;
    advance_to(150);
    @(negedge clk_50);
    chk("new_window_150", 32'(laser), 1);
    advance_to(323);
    @(negedge clk_50);
    chk("new_window_323", 32'(laser), 0);

    pulse_mid();
    repeat (5000) pulse_angle();
    chk("angle_saturate_5000", 32'(angle_cnt), 4095);
    chk("saturate_still_run", 32'(state), 2);

    en = 1'b0;
    @(negedge clk_50);
    chk("en_low_idle", 32'(state), 0);
    chk("en_low_idle_wd", 32'(state_wd), 0);
    chk("en_low_laser", 32'(laser), 0);
    write_entry(0, 1, 5, 1'b1);
    commit();
    @(negedge clk_50);
    chk("idle_commit_applied", 32'(commit_pending), 0);
    en = 1'b1;
    @(negedge clk_50);
    pulse_mid();
    chk("wd_run", 32'(state_wd), 2);
    repeat (999) @(negedge clk_50);
    chk("wd_last_run", 32'(state_wd), 2);
    chk("wd_last_laser", 32'(laser_wd), 1);
    @(negedge clk_50);
    chk("wd_fault_state", 32'(state_wd), 3);
    chk("wd_fault_flag", 32'(fault_wd), 1);
    chk("wd_fault_laser", 32'(laser_wd), 0);
    chk("main_still_run", 32'(state), 2);
    chk("main_laser_on", 32'(laser), 1);
    pulse_mid();
    chk("fault_sticky", 32'(state_wd), 3);
    en = 1'b0;
    @(negedge clk_50);
    chk("fault_exit_state", 32'(state_wd), 0);
    chk("fault_exit_flag", 32'(fault_wd), 0);
    en = 1'b1;
    @(negedge clk_50);
    pulse_mid();
    @(negedge clk_50);
    chk("rerun_laser_on", 32'(laser), 1);

    #2 rst = 1'b1;
    #1;
    chk("async_rst_laser", 32'(laser), 0);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_angle", 32'(angle_cnt), 1);
    chk("async_rst_laser_wd", 32'(laser_wd), 0);
    @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
    chk("post_rst_arm", 32'(state), 1);
    pulse_mid();
    @(negedge clk_50);
    chk("post_rst_run", 32'(state), 2);
    chk("post_rst_table_clear", 32'(laser), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
